nonce_dispatcher: RTL and testbench
===================================

# nonce_dispatcher

Sequences a pool of SHA-256 hash lanes for bitcoin nonce search. Takes a nonce range from the top level, issues one nonce per cycle to idle lanes, and collects per-lane completion and target-hit flags. Reports the first winning nonce and the hit count. Sits between the host/testbench start interface and the replicated `bitcoin_hash` lane datapaths.

## Interface
- `NUM_LANES`, default 16: number of hash lanes driven; range 1..32.
- `HIT_CNT_W`, default 16: width of the hit counter.

- `clk`  in  1  single clock, all logic rising-edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  begin a search; sampled only in IDLE.
- `nonce_base`  in  32  first nonce of the range; sampled with `start`.
- `nonce_count`  in  32  number of nonces to issue; sampled with `start`.
- `busy`  out  1  high whenever state is not IDLE.
- `done`  out  1  one-cycle pulse at search end.
- `found`  out  1  at least one hit recorded in the current/last search.
- `found_nonce`  out  32  nonce of the first recorded hit.
- `hit_count`  out  HIT_CNT_W  number of hits recorded, saturating.
- `lane_start`  out  NUM_LANES  per-lane one-cycle start pulse.
- `lane_nonce`  out  NUM_LANES*32  per-lane nonce; lane i occupies bits [32i+31:32i].
- `lane_done`  in  NUM_LANES  per-lane one-cycle completion pulse.
- `lane_hit`  in  NUM_LANES  per-lane hit flag; valid only with `lane_done`.

## Operation
- States: IDLE, DISPATCH, DRAIN, FINISH.
- **IDLE**
  - On `start`: `next_nonce <= nonce_base`, `remaining <= nonce_count`, clear `found`/`found_nonce`/`hit_count`.
  - Go to DISPATCH, or to FINISH if `nonce_count == 0`.
  - `start` is ignored in all other states.
- **DISPATCH**
  - Each cycle, if any lane's registered busy bit is clear, select the lowest-index idle lane.
  - For that lane: pulse `lane_start`, load its `lane_nonce` register with `next_nonce`, set its busy bit.
  - Then `next_nonce <= next_nonce + 1` (mod 2^32; 32'hFFFFFFFF wraps to 0) and `remaining <= remaining - 1`.
  - When the issue that takes `remaining` to 0 happens, go to DRAIN.
- **Completion** (every non-IDLE state)
  - `lane_done[i]` with busy bit i set clears busy bit i.
  - `lane_done` on a lane whose busy bit is clear is ignored.
  - A freed lane is eligible for issue the following cycle, never the same cycle.
- **Hit recording**
  - Each qualifying `lane_done & lane_hit` increments `hit_count`; multiple hits in one cycle add their popcount; the counter saturates at all-ones.
  - If `found == 0`: set `found`, and latch the `lane_nonce` of the lowest-index hitting lane into `found_nonce`.
- **DRAIN**: wait until all busy bits are clear, counting any `lane_done` arriving this cycle; then go to FINISH.
- **FINISH**: pulse `done` for one cycle, then go to IDLE.
- `found`, `found_nonce` and `hit_count` hold their values until the next accepted `start`.
- `lane_nonce[i]` is stable from its `lane_start` until the next `lane_start` to lane i.

## Timing
- Reset values: state IDLE; `busy`, `done`, `found` = 0; `found_nonce`, `hit_count`, `lane_start`, `lane_nonce` = 0; all busy bits 0.
- `start` accepted at edge N: first `lane_start` at edge N+1 (registered outputs).
- Issue throughput: at most one nonce per cycle.
- Search end: `done` is asserted one cycle after the last busy bit clears.
- `reset_n` low mid-search: immediate return to reset values. Outstanding lane results are discarded; lanes are reset by the same `reset_n`.

## Configuration
- `NONCE_DISP_STOP_ON_HIT_EN` defined:
  - On the first recorded hit in DISPATCH, stop issuing (remaining nonces are abandoned) and go to DRAIN.
  - Hits from in-flight lanes still increment `hit_count` but do not change `found_nonce`.
- Undefined: the full range is always swept; `hit_count` counts every hit.

## Structure
- Package `nonce_disp_pkg`:
  - state enum `nonce_disp_state_t`;
  - `NONCE_W = 32`;
  - helper function `popcount`.
- Sub-module `nonce_disp_prio_enc`: parameterised lowest-index-set-bit encoder (valid + index). Instantiated twice: idle-lane select and first-hit select.

## Test plan
- NUM_LANES=4; base 32'h00000010, count 6; lanes report done 20 cycles after their start, no hits.
  - Expect lane_start on lanes 0,1,2,3 with nonces 0x10..0x13 in consecutive cycles.
  - Expect 0x14 and 0x15 to go to lanes 0 and 1 after they free.
  - Expect one `done` pulse, `found=0`, `hit_count=0`.
- count 0: `done` pulses 2 cycles after `start`, no `lane_start`.
- base 32'hFFFFFFFE, count 3: issued nonces FFFFFFFE, FFFFFFFF, 00000000.
- Lanes 1 and 3 report a hit in the same cycle (nonces 0x11, 0x13):
  - `found_nonce=0x11`, `hit_count` increments by 2.
  - With `NONCE_DISP_STOP_ON_HIT_EN`, no further `lane_start` after that cycle.
- `reset_n` pulsed low during DISPATCH: all outputs return to 0 asynchronously; a subsequent `start` runs normally.
- Spurious `lane_done` on an idle lane plus `start` asserted while busy: both ignored, results unchanged.

Source files
------------

// File: rtl/nonce_disp_pkg.sv
// ---------------------------------------------------------------------------
// nonce_disp_pkg
//
// Shared definitions for the nonce dispatcher slice:
//   nonce_disp_state_t : dispatcher FSM states
//   NONCE_W            : nonce width (32 bits, bitcoin header nonce field)
//   popcount()         : number of set bits in a 32-bit vector, used to add
//                        several same-cycle lane hits to the hit counter
// ---------------------------------------------------------------------------
package nonce_disp_pkg;

    localparam int NONCE_W = 32;

    typedef enum logic [1:0] {
        IDLE,
        DISPATCH,
        DRAIN,
        FINISH
    } nonce_disp_state_t;

    // Lane vectors narrower than 32 bits are zero-extended by the caller, so
    // one fixed-width helper serves every NUM_LANES setting.
    function automatic logic [5:0] popcount(input logic [31:0] vec);
        logic [5:0] cnt;
        cnt = '0;
        for (int i = 0; i < 32; i++) begin
            cnt = cnt + {5'd0, vec[i]};
        end
        return cnt;
    endfunction

endpackage

// File: rtl/nonce_disp_prio_enc.sv
// ---------------------------------------------------------------------------
// nonce_disp_prio_enc
//
// Lowest-index-set-bit encoder. Used by the dispatcher both to pick the
// idle lane that receives the next nonce and to pick which hitting lane's
// nonce is reported as the winner.
//
// Parameters:
//   W     : request vector width
//   IDX_W : index width (at least 1 bit, even when W == 1)
// Ports:
//   req   in  W      request bits
//   valid out 1      at least one request bit set
//   idx   out IDX_W  index of the lowest set bit (0 when valid is low)
// ---------------------------------------------------------------------------
module nonce_disp_prio_enc #(
    parameter int W     = 16,
    parameter int IDX_W = (W > 1) ? $clog2(W) : 1
) (
    input  logic [W-1:0]     req,
    output logic             valid,
    output logic [IDX_W-1:0] idx
);

    // Scan from the top down so the last assignment made is the lowest set
    // bit, which gives lane 0 the highest priority.
    always_comb begin
        valid = |req;
        idx   = '0;
        for (int i = W - 1; i >= 0; i--) begin
            if (req[i]) begin
                idx = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/nonce_dispatcher.sv
// ---------------------------------------------------------------------------
// nonce_dispatcher
//
// Hands out a contiguous nonce range to a pool of SHA-256 hash lanes, one
// nonce per cycle to the lowest idle lane, and gathers per-lane completion
// and target-hit flags. Reports the first winning nonce and a saturating
// hit count, and pulses done once every issued nonce has come back.
//
// Parameters:
//   NUM_LANES : number of hash lanes (1..32)
//   HIT_CNT_W : hit counter width
// Ports:
//   clk          in   1                 rising-edge clock
//   reset_n      in   1                 asynchronous active-low reset
//   start        in   1                 begin a search (honoured in IDLE only)
//   nonce_base   in   32                first nonce, sampled with start
//   nonce_count  in   32                nonces to issue, sampled with start
//   busy         out  1                 state is not IDLE
//   done         out  1                 one-cycle end-of-search pulse
//   found        out  1                 a hit has been recorded
//   found_nonce  out  32                nonce of the first recorded hit
//   hit_count    out  HIT_CNT_W         saturating number of hits
//   lane_start   out  NUM_LANES         per-lane one-cycle start pulse
//   lane_nonce   out  NUM_LANES*32      lane i nonce at [32i+31:32i]
//   lane_done    in   NUM_LANES         per-lane completion pulse
//   lane_hit     in   NUM_LANES         per-lane hit, valid with lane_done
//
// Build option:
//   NONCE_DISP_STOP_ON_HIT_EN : when defined, the first hit seen while
//   dispatching abandons the rest of the range and drains in-flight lanes.
// ---------------------------------------------------------------------------
module nonce_dispatcher
    import nonce_disp_pkg::*;
#(
    parameter int NUM_LANES = 16,
    parameter int HIT_CNT_W = 16
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         start,
    input  logic [NONCE_W-1:0]           nonce_base,
    input  logic [NONCE_W-1:0]           nonce_count,
    output logic                         busy,
    output logic                         done,
    output logic                         found,
    output logic [NONCE_W-1:0]           found_nonce,
    output logic [HIT_CNT_W-1:0]         hit_count,
    output logic [NUM_LANES-1:0]         lane_start,
    output logic [NUM_LANES*NONCE_W-1:0] lane_nonce,
    input  logic [NUM_LANES-1:0]         lane_done,
    input  logic [NUM_LANES-1:0]         lane_hit
);

    localparam int LANE_IDX_W = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;

    nonce_disp_state_t state, state_nx;

    logic [NONCE_W-1:0]    next_nonce;
    logic [NONCE_W-1:0]    remaining;
    logic [NUM_LANES-1:0]  lane_busy;
    logic [NUM_LANES-1:0]  lane_start_r;
    logic [NONCE_W-1:0]    lane_nonce_r [NUM_LANES];
    logic                  found_r;
    logic [NONCE_W-1:0]    found_nonce_r;
    logic [HIT_CNT_W-1:0]  hit_count_r;
    logic                  done_r;

    logic                  active;
    logic [NUM_LANES-1:0]  done_q;
    logic [NUM_LANES-1:0]  hit_q;
    logic [NUM_LANES-1:0]  busy_after_done;
    logic [NUM_LANES-1:0]  issue_oh;
    logic [31:0]           hit_vec;
    logic [5:0]            hit_pop;
    logic [HIT_CNT_W+5:0]  hit_sum;
    logic [HIT_CNT_W-1:0]  hit_count_nx;
    logic [NONCE_W-1:0]    first_hit_nonce;
    logic                  idle_valid;
    logic [LANE_IDX_W-1:0] idle_idx;
    logic                  hit_valid;
    logic [LANE_IDX_W-1:0] hit_idx;
    logic                  stop_now;
    logic                  issue;

    // Idle-lane selection works on the registered busy bits, so a lane that
    // completes this cycle only becomes eligible on the next one.
    nonce_disp_prio_enc #(
        .W     (NUM_LANES),
        .IDX_W (LANE_IDX_W)
    ) u_idle_sel (
        .req   (~lane_busy),
        .valid (idle_valid),
        .idx   (idle_idx)
    );

    // Among the lanes reporting a hit this cycle, the lowest index wins the
    // found_nonce slot.
    nonce_disp_prio_enc #(
        .W     (NUM_LANES),
        .IDX_W (LANE_IDX_W)
    ) u_hit_sel (
        .req   (hit_q),
        .valid (hit_valid),
        .idx   (hit_idx)
    );

    // Qualify lane completions against the busy bits (stray pulses from idle
    // lanes are dropped), and work out the saturating hit count and the
    // nonce belonging to the first hitting lane.
    always_comb begin
        active          = (state != IDLE);
        done_q          = active ? (lane_done & lane_busy) : '0;
        hit_q           = done_q & lane_hit;
        busy_after_done = lane_busy & ~done_q;

        hit_vec                  = '0;
        hit_vec[NUM_LANES-1:0]   = hit_q;
        hit_pop                  = popcount(hit_vec);
        hit_sum                  = {6'd0, hit_count_r} + {{HIT_CNT_W{1'b0}}, hit_pop};
        hit_count_nx             = (|hit_sum[HIT_CNT_W+5:HIT_CNT_W]) ? '1 : hit_sum[HIT_CNT_W-1:0];

        first_hit_nonce = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            if (hit_idx == LANE_IDX_W'(i)) begin
                first_hit_nonce = lane_nonce_r[i];
            end
        end
    end

    // Decide whether a nonce goes out this cycle. With stop-on-hit, the
    // cycle that records the first hit also issues nothing, so no lane_start
    // ever follows the winning result.
    always_comb begin
`ifdef NONCE_DISP_STOP_ON_HIT_EN
        stop_now = (state == DISPATCH) && hit_valid && !found_r;
`else
        stop_now = 1'b0;
`endif
        issue = (state == DISPATCH) && idle_valid && !stop_now;

        issue_oh = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            issue_oh[i] = issue && (idle_idx == LANE_IDX_W'(i));
        end
    end

    // Next-state logic. DISPATCH leaves on the issue that uses up the range;
    // DRAIN leaves once no lane would still be busy after this cycle's
    // completions are applied.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nx = (nonce_count == '0) ? FINISH : DISPATCH;
                end
            end
            DISPATCH: begin
                if (stop_now) begin
                    state_nx = DRAIN;
                end else if (issue && (remaining == 32'd1)) begin
                    state_nx = DRAIN;
                end
            end
            DRAIN: begin
                if (busy_after_done == '0) begin
                    state_nx = FINISH;
                end
            end
            FINISH: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Datapath registers: lane bookkeeping, range counters and results.
    // Results are cleared only by an accepted start, so they remain readable
    // after done until the next search begins.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            next_nonce    <= '0;
            remaining     <= '0;
            lane_busy     <= '0;
            lane_start_r  <= '0;
            found_r       <= 1'b0;
            found_nonce_r <= '0;
            hit_count_r   <= '0;
            done_r        <= 1'b0;
            for (int i = 0; i < NUM_LANES; i++) begin
                lane_nonce_r[i] <= '0;
            end
        end else begin
            lane_start_r <= issue_oh;
            lane_busy    <= busy_after_done | issue_oh;
            done_r       <= (state == FINISH);
            for (int i = 0; i < NUM_LANES; i++) begin
                if (issue_oh[i]) begin
                    lane_nonce_r[i] <= next_nonce;
                end
            end

            if ((state == IDLE) && start) begin
                next_nonce    <= nonce_base;
                remaining     <= nonce_count;
                found_r       <= 1'b0;
                found_nonce_r <= '0;
                hit_count_r   <= '0;
            end else begin
                if (issue) begin
                    next_nonce <= next_nonce + 32'd1;
                    remaining  <= remaining - 32'd1;
                end
                if (hit_valid) begin
                    hit_count_r <= hit_count_nx;
                    if (!found_r) begin
                        found_r       <= 1'b1;
                        found_nonce_r <= first_hit_nonce;
                    end
                end
            end
        end
    end

    assign busy        = (state != IDLE);
    assign done        = done_r;
    assign found       = found_r;
    assign found_nonce = found_nonce_r;
    assign hit_count   = hit_count_r;
    assign lane_start  = lane_start_r;

    for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane_nonce
        assign lane_nonce[g*NONCE_W +: NONCE_W] = lane_nonce_r[g];
    end

endmodule

// File: tb/tb_nonce_dispatcher.sv
// ---------------------------------------------------------------------------
// tb_nonce_dispatcher
//
// Directed bench for nonce_dispatcher with four lanes. A lane model answers
// each lane_start with lane_done a programmable number of cycles later and
// raises lane_hit when the lane's nonce is one of the chosen winners.
// Expected issues and expected search results are queued by the stimulus
// and checked by an independent monitor whenever the DUT presents them.
// ---------------------------------------------------------------------------
module tb_nonce_dispatcher;

    localparam int NL  = 4;
    localparam int HCW = 16;

    logic            clk;
    logic            reset_n;
    logic            start;
    logic [31:0]     nonce_base;
    logic [31:0]     nonce_count;
    logic            busy;
    logic            done;
    logic            found;
    logic [31:0]     found_nonce;
    logic [HCW-1:0]  hit_count;
    logic [NL-1:0]   lane_start;
    logic [NL*32-1:0] lane_nonce;
    logic [NL-1:0]   lane_done;
    logic [NL-1:0]   lane_hit;

    typedef struct {
        int          lane;
        logic [31:0] nonce;
    } issue_t;

    typedef struct {
        logic        found;
        logic [31:0] nonce;
        int          hits;
    } result_t;

    issue_t  exp_issue[$];
    result_t exp_result[$];

    int checks   = 0;
    int failures = 0;

    int          lat      [NL];
    int          cnt      [NL];
    logic        hit_flag [NL];
    logic        hits_en;
    logic [31:0] hit_a;
    logic [31:0] hit_b;
    logic [NL-1:0] spur_req;

    nonce_dispatcher #(
        .NUM_LANES (NL),
        .HIT_CNT_W (HCW)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .start       (start),
        .nonce_base  (nonce_base),
        .nonce_count (nonce_count),
        .busy        (busy),
        .done        (done),
        .found       (found),
        .found_nonce (found_nonce),
        .hit_count   (hit_count),
        .lane_start  (lane_start),
        .lane_nonce  (lane_nonce),
        .lane_done   (lane_done),
        .lane_hit    (lane_hit)
    );

    // Free-running clock, rising edges at 5, 15, 25 ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic [31:0] base, input logic [31:0] count);
        @(negedge clk);
        start       = 1'b1;
        nonce_base  = base;
        nonce_count = count;
        @(negedge clk);
        start       = 1'b0;
    endtask

    task automatic pushIssue(input int lane, input logic [31:0] nonce);
        issue_t e;
        e.lane  = lane;
        e.nonce = nonce;
        exp_issue.push_back(e);
    endtask

    task automatic pushResult(input logic f, input logic [31:0] n, input int h);
        result_t r;
        r.found = f;
        r.nonce = n;
        r.hits  = h;
        exp_result.push_back(r);
    endtask

    task automatic waitDone(input int budget, input string name);
        bit seen;
        seen = 1'b0;
        for (int c = 0; c < budget && !seen; c++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        checkOutput(name, 64'(seen), 64'd1);
    endtask

    task automatic checkReset(input string tag);
        checkOutput({tag, "_busy"}, 64'(busy), 64'd0);
        checkOutput({tag, "_done"}, 64'(done), 64'd0);
        checkOutput({tag, "_found"}, 64'(found), 64'd0);
        checkOutput({tag, "_found_nonce"}, 64'(found_nonce), 64'd0);
        checkOutput({tag, "_hit_count"}, 64'(hit_count), 64'd0);
        checkOutput({tag, "_lane_start"}, 64'(lane_start), 64'd0);
        for (int i = 0; i < NL; i++) begin
            checkOutput($sformatf("%s_lane_nonce%0d", tag, i), 64'(lane_nonce[32*i +: 32]), 64'd0);
        end
    endtask

    // Lane model: reacts just after each rising edge. A lane started with
    // latency L drives lane_done for one cycle L edges later; spur_req
    // injects a one-cycle done+hit on chosen lanes regardless of state.
    initial begin
        lane_done = '0;
        lane_hit  = '0;
        for (int i = 0; i < NL; i++) begin
            cnt[i]      = 0;
            hit_flag[i] = 1'b0;
        end
        forever begin
            @(posedge clk);
            #1;
            lane_done = '0;
            lane_hit  = '0;
            if (!reset_n) begin
                for (int i = 0; i < NL; i++) cnt[i] = 0;
            end else begin
                for (int i = 0; i < NL; i++) begin
                    if (cnt[i] > 0) begin
                        cnt[i]--;
                        if (cnt[i] == 0) begin
                            lane_done[i] = 1'b1;
                            lane_hit[i]  = hit_flag[i];
                        end
                    end
                end
                for (int i = 0; i < NL; i++) begin
                    if (lane_start[i]) begin
                        cnt[i]      = lat[i];
                        hit_flag[i] = hits_en && ((lane_nonce[32*i +: 32] == hit_a) || (lane_nonce[32*i +: 32] == hit_b));
                    end
                end
                lane_done = lane_done | spur_req;
                lane_hit  = lane_hit | spur_req;
                spur_req  = '0;
            end
        end
    end

    // Monitor: every lane_start must match the next queued issue, and every
    // done pulse must match the next queued search result.
    initial begin
        forever begin
            @(negedge clk);
            if (reset_n) begin
                if (lane_start != '0) begin
                    checkOutput("one_start_per_cycle", 64'($countones(lane_start)), 64'd1);
                    for (int i = 0; i < NL; i++) begin
                        if (lane_start[i]) begin
                            if (exp_issue.size() == 0) begin
                                checks++;
                                failures++;
                                $display("[TB] FAIL unexpected_lane_start: got lane %0d nonce 0x%0h, expected none", i, lane_nonce[32*i +: 32]);
                            end else begin
                                issue_t e;
                                e = exp_issue.pop_front();
                                checkOutput("issue_lane", 64'(i), 64'(e.lane));
                                checkOutput("issue_nonce", 64'(lane_nonce[32*i +: 32]), 64'(e.nonce));
                            end
                        end
                    end
                end
                if (done) begin
                    if (exp_result.size() == 0) begin
                        checks++;
                        failures++;
                        $display("[TB] FAIL unexpected_done: got done=1, expected none");
                    end else begin
                        result_t r;
                        r = exp_result.pop_front();
                        checkOutput("result_found", 64'(found), 64'(r.found));
                        checkOutput("result_found_nonce", 64'(found_nonce), 64'(r.nonce));
                        checkOutput("result_hit_count", 64'(hit_count), 64'(r.hits));
                    end
                end
            end
        end
    end

    // Watchdog so a stuck DUT still ends the run.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got no end of test, expected completion");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset_n     = 1'b0;
        start       = 1'b0;
        nonce_base  = '0;
        nonce_count = '0;
        spur_req    = '0;
        hits_en     = 1'b0;
        hit_a       = '0;
        hit_b       = '0;
        for (int i = 0; i < NL; i++) lat[i] = 20;

        // Reset values.
        repeat (3) @(negedge clk);
        checkReset("reset");
        reset_n = 1'b1;
        @(negedge clk);

        // Range sweep 0x10..0x15; first four fill the lanes, the last two
        // reuse lanes 0 and 1 once they free up.
        $display("[TB] sweep base 0x10 count 6");
        pushIssue(0, 32'h10);
        pushIssue(1, 32'h11);
        pushIssue(2, 32'h12);
        pushIssue(3, 32'h13);
        pushIssue(0, 32'h14);
        pushIssue(1, 32'h15);
        pushResult(1'b0, 32'h0, 0);
        applyStimulus(32'h10, 32'd6);
        checkOutput("start_latency_edge0", 64'(lane_start), 64'd0);
        @(negedge clk);
        checkOutput("start_latency_edge1", 64'(lane_start), 64'd1);
        waitDone(200, "sweep_done_timeout");
        checkOutput("sweep_busy_after_done", 64'(busy), 64'd0);

        // Empty range: done two cycles after start, nothing issued.
        $display("[TB] empty range");
        pushResult(1'b0, 32'h0, 0);
        applyStimulus(32'h55, 32'd0);
        checkOutput("empty_done_early", 64'(done), 64'd0);
        checkOutput("empty_busy", 64'(busy), 64'd1);
        @(negedge clk);
        checkOutput("empty_done", 64'(done), 64'd1);
        checkOutput("empty_busy_clear", 64'(busy), 64'd0);
        @(negedge clk);
        checkOutput("empty_done_one_cycle", 64'(done), 64'd0);

        // Nonce wrap-around at the top of the 32-bit space.
        $display("[TB] wrap base 0xFFFFFFFE count 3");
        pushIssue(0, 32'hFFFF_FFFE);
        pushIssue(1, 32'hFFFF_FFFF);
        pushIssue(2, 32'h0000_0000);
        pushResult(1'b0, 32'h0, 0);
        applyStimulus(32'hFFFF_FFFE, 32'd3);
        waitDone(200, "wrap_done_timeout");

        // Lanes 1 and 3 (nonces 0x11, 0x13) hit in the same cycle; lane 1's
        // longer latency lines the two completions up.
        $display("[TB] double hit");
        lat[1]  = 22;
        hits_en = 1'b1;
        hit_a   = 32'h11;
        hit_b   = 32'h13;
        pushIssue(0, 32'h10);
        pushIssue(1, 32'h11);
        pushIssue(2, 32'h12);
        pushIssue(3, 32'h13);
        pushIssue(0, 32'h14);
`ifndef NONCE_DISP_STOP_ON_HIT_EN
        pushIssue(2, 32'h15);
`endif
        pushResult(1'b1, 32'h11, 2);
        applyStimulus(32'h10, 32'd6);
        waitDone(200, "hit_done_timeout");
        repeat (3) @(negedge clk);
        checkOutput("hit_found_hold", 64'(found), 64'd1);
        checkOutput("hit_found_nonce_hold", 64'(found_nonce), 64'h11);
        checkOutput("hit_count_hold", 64'(hit_count), 64'd2);

        // Stray done+hit on idle lane 3 and a start while busy: both ignored.
        $display("[TB] spurious done and busy start");
        lat[1] = 20;
        hit_a  = 32'h41;
        hit_b  = 32'h41;
        pushIssue(0, 32'h40);
        pushIssue(1, 32'h41);
        pushResult(1'b1, 32'h41, 1);
        applyStimulus(32'h40, 32'd2);
        repeat (3) @(negedge clk);
        spur_req    = 4'b1000;
        start       = 1'b1;
        nonce_base  = 32'h99;
        nonce_count = 32'd5;
        @(negedge clk);
        start = 1'b0;
        waitDone(200, "spur_done_timeout");
        checkOutput("spur_lane3_nonce", 64'(lane_nonce[96 +: 32]), 64'h13);

        // Asynchronous reset in the middle of dispatch, then a clean rerun.
        $display("[TB] reset during dispatch");
        hits_en = 1'b0;
        pushIssue(0, 32'h100);
        pushIssue(1, 32'h101);
        pushIssue(2, 32'h102);
        pushIssue(3, 32'h103);
        applyStimulus(32'h100, 32'd10);
        repeat (5) @(negedge clk);
        #3;
        reset_n = 1'b0;
        #1;
        checkReset("async_reset");
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        pushIssue(0, 32'h200);
        pushIssue(1, 32'h201);
        pushResult(1'b0, 32'h0, 0);
        applyStimulus(32'h200, 32'd2);
        waitDone(200, "rerun_done_timeout");

        repeat (3) @(negedge clk);
        checkOutput("issue_queue_drained", 64'(exp_issue.size()), 64'd0);
        checkOutput("result_queue_drained", 64'(exp_result.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
